regfile_dump_ctrl: RTL and testbench
====================================

# regfile_dump_ctrl

Debug/test controller that reads architectural registers out of the 32×32 register file through one combinational read port. It streams them over a valid/ready output channel, either a full dump of all registers or a single register. Before reading, it stalls the pipeline with a halt_req/halt_ack handshake so the snapshot is consistent. It sits beside the core's register file and feeds the debug transport.

## Interface
- NUM_REGS, 32: registers walked in a full dump; indices 0..NUM_REGS-1.
- ADDR_W, 5: register index width; NUM_REGS ≤ 2^ADDR_W.
- DATA_W, 32: register data width.
- HALT_TIMEOUT, 255: maximum cycles spent waiting for halt_ack before aborting; must be ≥ 1.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request for a full dump; sampled only in IDLE.
- single_req  in  1  one-cycle request to read one register; sampled only in IDLE.
- single_addr  in  ADDR_W  register index for single_req; latched with the request.
- halt_req  out  1  stall request to the pipeline; registered.
- halt_ack  in  1  pipeline stalled and the register file is quiescent.
- rf_addr  out  ADDR_W  drives a register-file read address; registered.
- rf_data  in  DATA_W  combinational read data for rf_addr.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  captured register value.
- out_addr  out  ADDR_W  index of out_data.
- out_last  out  1  final word of the current request.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a request finishes or aborts.
- err  out  1  valid with done; 1 means the halt timed out.

## Operation
- States: IDLE, HALT_WAIT, READ, SEND, RELEASE.
- IDLE:
  - start=1 → mode=DUMP, idx=0.
  - else single_req=1 → mode=SINGLE, idx=single_addr.
  - Either request: halt_req←1, tcnt←0, go to HALT_WAIT.
  - start has priority when both are asserted. Requests outside IDLE are ignored (no queueing).
- HALT_WAIT:
  - halt_ack=1 → READ.
  - Otherwise tcnt increments. When tcnt reaches HALT_TIMEOUT−1 without an ack: halt_req←0, done=1, err=1, go to IDLE.
- READ:
  - rf_addr holds idx.
  - On the edge: out_data←rf_data, out_addr←idx, out_valid←1, and out_last←1 when (mode=SINGLE or idx=NUM_REGS−1). Go to SEND.
- SEND:
  - out_valid, out_data, out_addr and out_last are held stable until out_ready=1.
  - On handshake, out_valid←0.
  - If out_last: go to RELEASE.
  - Otherwise idx←idx+1, rf_addr←idx+1, go to READ.
- RELEASE: halt_req←0, done=1, err=0, go to IDLE.
- Register 0 is read and streamed like any other index; its value comes from the register file (zero).
- halt_ack is sampled only in HALT_WAIT. The pipeline must keep stalling for as long as halt_req is high.
- idx never wraps: a dump ends at NUM_REGS−1.

## Timing
- Reset values: all outputs 0, state IDLE, idx=0, tcnt=0.
- halt_req and the output channel drop asynchronously when rst asserts.
- Reset mid-request aborts with no done pulse.
- Latency with halt_ack held high and out_ready=1:
  - start sampled at edge 0; halt_req high after edge 0.
  - READ entered after edge 1; out_valid first high after edge 2.
  - One word every 2 cycles.
  - Full dump: done pulses after edge 2·NUM_REGS+2; halt_req low from the same edge.
- With out_ready=0, SEND is held indefinitely; there is no output timeout.
- done and err are combinationally derived from the state transition, or registered; either way they are high for exactly one cycle, and err=0 whenever done=0.
- rf_data must settle within one cycle of a change on rf_addr.

## Test plan
- Preload register i = 0x1000_0000+i (register 0 reads 0). Pulse start with halt_ack tied 1 and out_ready=1 → 32 words, out_addr 0..31 with matching data, out_last only on addr 31, done=1 and err=0 once, halt_req high for the whole dump.
- single_req with single_addr=7 (register 7 = 0xDEADBEEF) → exactly one word {addr 7, 0xDEADBEEF, last=1}, then done.
- out_ready toggling randomly during a dump → each word is held stable while out_valid=1 && out_ready=0; no word is lost or duplicated.
- halt_ack never asserted with HALT_TIMEOUT=8 → halt_req drops after 8 cycles in HALT_WAIT, done=1 with err=1, out_valid never rises.
- start and single_req in the same cycle → full dump runs. A start pulse during busy is ignored and no second dump follows.
- rst asserted during SEND at word 10 → halt_req, out_valid and busy go 0 immediately with no done pulse. A fresh start afterwards dumps from address 0.

Source files
------------

// File: rtl/regfile_dump_if.sv
// Request, halt handshake, register-file read port and output stream of the
// register dump controller, bundled for the controller and its environment.
interface regfile_dump_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              single_req;
  logic [ADDR_W-1:0] single_addr;
  logic              halt_req;
  logic              halt_ack;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  // Environment side: requester, pipeline, register file and stream consumer.
  modport master (
    output start, single_req, single_addr, halt_ack, rf_data, out_ready,
    input  halt_req, rf_addr, out_valid, out_data, out_addr, out_last,
    input  busy, done, err
  );

  // Controller side.
  modport slave (
    input  start, single_req, single_addr, halt_ack, rf_data, out_ready,
    output halt_req, rf_addr, out_valid, out_data, out_addr, out_last,
    output busy, done, err
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Halts the pipeline, then streams either every architectural register or a
// single one out of the register file over a valid/ready channel.
module regfile_dump_ctrl #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  regfile_dump_if.slave  bus
);

  localparam int unsigned       TCNT_W   = $clog2(HALT_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT_WAIT,
    ST_READ,
    ST_SEND,
    ST_RELEASE
  } state_e;

  state_e            state_q,     state_d;
  logic              single_q,    single_d;
  logic [ADDR_W-1:0] idx_q,       idx_d;
  logic [TCNT_W-1:0] tcnt_q,      tcnt_d;
  logic              halt_req_q,  halt_req_d;
  logic [ADDR_W-1:0] rf_addr_q,   rf_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_last_q,  out_last_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    single_d    = single_q;
    idx_d       = idx_q;
    tcnt_d      = tcnt_q;
    halt_req_d  = halt_req_q;
    rf_addr_d   = rf_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start wins over single_req; rf_addr is set up now so READ sees settled data.
        if (bus.start || bus.single_req) begin
          single_d   = !bus.start;
          idx_d      = bus.start ? '0 : bus.single_addr;
          rf_addr_d  = bus.start ? '0 : bus.single_addr;
          halt_req_d = 1'b1;
          tcnt_d     = '0;
          state_d    = ST_HALT_WAIT;
        end
      end

      ST_HALT_WAIT: begin
        if (bus.halt_ack) begin
          state_d = ST_READ;
        end else if (tcnt_q == TCNT_MAX) begin
          halt_req_d = 1'b0;
          done_d     = 1'b1;
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      ST_READ: begin
        out_data_d  = bus.rf_data;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
        out_last_d  = single_q || (idx_q == LAST_IDX);
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_RELEASE;
          end else begin
            idx_d     = idx_q + ADDR_W'(1);
            rf_addr_d = idx_q + ADDR_W'(1);
            state_d   = ST_READ;
          end
        end
      end

      ST_RELEASE: begin
        halt_req_d = 1'b0;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        halt_req_d  = 1'b0;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State register; reset drops the halt request and output channel at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      single_q    <= 1'b0;
      idx_q       <= '0;
      tcnt_q      <= '0;
      halt_req_q  <= 1'b0;
      rf_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      single_q    <= single_d;
      idx_q       <= idx_d;
      tcnt_q      <= tcnt_d;
      halt_req_q  <= halt_req_d;
      rf_addr_q   <= rf_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.halt_req  = halt_req_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: directed and random dump/single requests checked
// against an expected-word queue built from a register-file array.
module tb_regfile_dump_ctrl;

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned HTO   = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rf_mem [NREGS];
  int            n_cmp = 0;
  int            n_mis = 0;

  regfile_dump_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_dump_ctrl #(
    .NUM_REGS    (NREGS),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .HALT_TIMEOUT(HTO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.rf_data = rf_mem[bus.rf_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one request from a negedge; iteration it is observed just after edge it.
  task automatic run_req(input bit do_start, input bit do_single, input logic [AW-1:0] saddr,
                         input int rdy_pct, input int ack_delay, input int inject_iter,
                         input int abort_addr, input bit exp_err, input bit check_lat);
    word_t      exp_q[$];
    word_t      cur, e;
    logic [38:0] held;
    bit         hold = 0, rdy, aborted = 0, finished = 0;
    int         done_iter = -1, first_valid = -1, done_cnt = 0, halt_cyc = 0;
    int         err_stray = 0, halt_gap = 0, busy_after = 0, nw;
    logic       err_at_done = 1'b0, halt_at_done = 1'b1;

    if (ack_delay >= 0) begin
      if (do_start) for (int i = 0; i < NREGS; i++)
        exp_q.push_back('{addr: AW'(i), data: rf_mem[i], last: (i == NREGS - 1)});
      else if (do_single)
        exp_q.push_back('{addr: saddr, data: rf_mem[saddr], last: 1'b1});
    end
    nw = exp_q.size();

    bus.start       = do_start;
    bus.single_req  = do_single;
    bus.single_addr = saddr;
    bus.out_ready   = 1'b0;
    bus.halt_ack    = 1'b0;

    for (int it = 0; it < 4000 && !finished && !aborted; it++) begin
      @(negedge clk);
      bus.start      = (it == inject_iter);
      bus.single_req = 1'b0;
      cur = '{addr: bus.out_addr, data: bus.out_data, last: bus.out_last};

      if (abort_addr >= 0 && bus.out_valid && bus.out_addr == AW'(abort_addr)) begin
        rst = 1'b1;
        #1;
        chk("rst_halt_req", bus.halt_req, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        repeat (3) begin
          @(negedge clk);
          if (bus.done) done_cnt++;
        end
        chk("rst_no_done", done_cnt, 0);
        rst = 1'b0;
        aborted = 1;
      end else begin
        if (hold) chk("hold_stable", {bus.out_valid, cur}, held);
        if (bus.out_valid && first_valid < 0) first_valid = it;
        if (bus.out_valid && !bus.halt_req) halt_gap++;
        if (bus.err && !bus.done) err_stray++;
        if (done_iter < 0 && bus.halt_req) halt_cyc++;
        if (done_iter >= 0 && bus.busy) busy_after++;
        if (bus.done) begin
          done_cnt++;
          if (done_iter < 0) begin
            done_iter    = it;
            err_at_done  = bus.err;
            halt_at_done = bus.halt_req;
          end
        end

        rdy = ($urandom_range(99) < rdy_pct);
        bus.out_ready = rdy;
        bus.halt_ack  = bus.halt_req && (ack_delay >= 0) && (it >= ack_delay);
        if (bus.out_valid && rdy) begin
          if (exp_q.size() == 0) chk("extra_word", {1'b1, cur}, 0);
          else begin
            e = exp_q.pop_front();
            chk("word", cur, e);
          end
        end
        hold = bus.out_valid && !rdy;
        held = {bus.out_valid, cur};
        if (done_iter >= 0 && it >= done_iter + 10) finished = 1;
      end
    end

    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.halt_ack  = 1'b0;
    if (aborted) return;
    if (!finished) chk("req_timeout", 0, 1);
    chk("done_cnt", done_cnt, 1);
    chk("err_at_done", err_at_done, exp_err);
    chk("halt_at_done", halt_at_done, 0);
    chk("words_left", exp_q.size(), 0);
    chk("err_stray", err_stray, 0);
    chk("halt_gap", halt_gap, 0);
    chk("busy_after_done", busy_after, 0);
    if (exp_err) begin
      chk("to_halt_cycles", halt_cyc, HTO);
      chk("to_done_iter", done_iter, HTO);
      chk("to_no_valid", first_valid, -1);
    end
    if (check_lat) begin
      chk("lat_first_valid", first_valid, 2);
      chk("lat_done", done_iter, 2 * nw + 2);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.single_req  = 1'b0;
    bus.single_addr = '0;
    bus.halt_ack    = 1'b0;
    bus.out_ready   = 1'b0;
    for (int i = 0; i < NREGS; i++) rf_mem[i] = (i == 0) ? '0 : 32'h1000_0000 + DW'(i);

    #3;
    chk("reset_halt_req", bus.halt_req, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_rf_addr", bus.rf_addr, 0);
    chk("reset_out_word", {bus.out_addr, bus.out_data, bus.out_last}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full dump, everything ready: latency and content.
    run_req(1, 0, '0, 100, 0, -1, -1, 0, 1);
    // Single register 7.
    rf_mem[7] = 32'hDEAD_BEEF;
    run_req(0, 1, AW'(7), 100, 0, -1, -1, 0, 1);
    // Consumer back-pressure during a dump.
    run_req(1, 0, '0, 45, 2, -1, -1, 0, 0);
    // Halt never acknowledged.
    run_req(1, 0, '0, 100, -1, -1, -1, 1, 0);
    // Simultaneous start/single_req, plus a start pulse while busy.
    run_req(1, 1, AW'(3), 100, 0, 20, -1, 0, 0);
    // Reset at word 10, then a fresh dump from address 0.
    run_req(1, 0, '0, 70, 1, -1, 10, 0, 0);
    run_req(1, 0, '0, 100, 0, -1, -1, 0, 1);

    // Random contents, request kinds, ack delays and ready rates.
    for (int r = 0; r < 8; r++) begin
      for (int i = 1; i < NREGS; i++) rf_mem[i] = $urandom;
      run_req(($urandom_range(1) == 1), 1'b1, AW'($urandom_range(NREGS - 1)),
              int'($urandom_range(100, 30)), int'($urandom_range(6)), -1, -1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
